// File: rtl/serpent_subkey_store.sv
// ============================================================================
// Module   : serpent_subkey_store
// Function : Captures the 33 Serpent round subkeys and streams them in
//            ascending (encrypt) or descending (decrypt) order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serpent_subkey_store #(
    parameter int NUM_KEYS = 33,
    parameter int KEY_W    = 128,
    parameter int ADDR_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [KEY_W-1:0]  i_wr_data,
    input  logic              i_load_done,
    input  logic              i_start,
    input  logic              i_decrypt,
    output logic [KEY_W-1:0]  o_key,
    output logic [ADDR_W-1:0] o_key_idx,
    output logic              o_key_valid,
    input  logic              i_key_ready,
    output logic              o_last,
    output logic              o_ready,
    output logic              o_err
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2,
        STREAM  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_KEYS - 1);

    state_t              state, state_nx;
    logic [KEY_W-1:0]    mem [NUM_KEYS];
    logic [NUM_KEYS-1:0] lmask, lmask_nx, wr_bit, lmask_wr;
    logic                dir, dir_nx;
    logic                wr_ok, wr_bad, hs, key_load, err_nx, last_nx;
    logic [ADDR_W-1:0]   idx_nx;

    assign wr_ok    = i_wr_en && (i_wr_addr < ADDR_W'(NUM_KEYS));
    assign wr_bad   = i_wr_en && !wr_ok;
    assign wr_bit   = wr_ok ? (NUM_KEYS'(1) << i_wr_addr) : '0;
    assign lmask_wr = lmask | wr_bit;
    assign hs       = o_key_valid && i_key_ready;

    assign o_key_valid = (state == STREAM);
    assign o_ready     = (state == READY);

    always_comb begin
        state_nx = state;
        lmask_nx = lmask;
        dir_nx   = dir;
        key_load = 1'b0;
        idx_nx   = o_key_idx;
        last_nx  = o_last;
        err_nx   = wr_bad;
        case (state)
            EMPTY: begin
                if (wr_ok) begin
                    lmask_nx = lmask_wr;
                    state_nx = LOADING;
                end
                if (i_start) err_nx = 1'b1;
            end
            LOADING: begin
                // A same-cycle write is counted before the completeness check.
                lmask_nx = lmask_wr;
                if (i_load_done) begin
                    if (&lmask_wr) begin
                        state_nx = READY;
                    end else begin
                        err_nx   = 1'b1;
                        lmask_nx = '0;
                        state_nx = EMPTY;
                    end
                end
                if (i_start) err_nx = 1'b1;
            end
            READY: begin
                if (wr_ok) begin
                    lmask_nx = wr_bit;
                    state_nx = LOADING;
                    if (i_start) err_nx = 1'b1;
                end else if (i_start) begin
                    dir_nx   = i_decrypt;
                    key_load = 1'b1;
                    idx_nx   = i_decrypt ? LAST_IDX : '0;
                    last_nx  = 1'b0;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (i_wr_en || i_start) err_nx = 1'b1;
                if (hs) begin
                    if (o_last) begin
                        last_nx  = 1'b0;
                        state_nx = READY;
                    end else begin
                        key_load = 1'b1;
                        idx_nx   = dir ? (o_key_idx - 1'b1) : (o_key_idx + 1'b1);
                        last_nx  = dir ? (idx_nx == '0) : (idx_nx == LAST_IDX);
                    end
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= EMPTY;
            lmask     <= '0;
            dir       <= 1'b0;
            o_key     <= '0;
            o_key_idx <= '0;
            o_last    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state  <= state_nx;
            lmask  <= lmask_nx;
            dir    <= dir_nx;
            o_last <= last_nx;
            o_err  <= err_nx;
            if (key_load) begin
                o_key     <= mem[idx_nx];
                o_key_idx <= idx_nx;
            end
        end
    end

    // Key storage is frozen while streaming so a block never sees mixed keys.
    always_ff @(posedge i_clk) begin
        if (wr_ok && state != STREAM) mem[i_wr_addr] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_serpent_subkey_store.sv
// ============================================================================
// Module   : tb_serpent_subkey_store
// Function : Directed self-checking bench for serpent_subkey_store.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serpent_subkey_store;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_wr_en = 1'b0;
    logic [5:0]   i_wr_addr = '0;
    logic [127:0] i_wr_data = '0;
    logic         i_load_done = 1'b0;
    logic         i_start = 1'b0;
    logic         i_decrypt = 1'b0;
    logic         i_key_ready = 1'b0;
    logic [127:0] o_key;
    logic [5:0]   o_key_idx;
    logic         o_key_valid, o_last, o_ready, o_err;

    int tests = 0;
    int fails = 0;

    serpent_subkey_store dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_load_done (i_load_done),
        .i_start     (i_start),
        .i_decrypt   (i_decrypt),
        .o_key       (o_key),
        .o_key_idx   (o_key_idx),
        .o_key_valid (o_key_valid),
        .i_key_ready (i_key_ready),
        .o_last      (o_last),
        .o_ready     (o_ready),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [127:0] kv(input int i);
        logic [7:0] b;
        b  = i[7:0];
        kv = {16{b}};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_range(input int last);
        for (int i = 0; i <= last; i++) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 6'(i);
            i_wr_data = kv(i);
            tick();
            check("load_err", o_err, 0);
        end
        i_wr_en = 1'b0;
    endtask

    task automatic load_done_ok();
        i_load_done = 1'b1;
        tick();
        i_load_done = 1'b0;
        check("load_ready", o_ready, 1);
        check("load_done_err", o_err, 0);
    endtask

    task automatic stream_asc(input bit inject, input int stop_at);
        i_decrypt   = 1'b0;
        i_key_ready = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        check("asc_ready_fall", o_ready, 0);
        for (int k = 0; k <= stop_at; k++) begin
            check("asc_valid", o_key_valid, 1);
            check("asc_idx", o_key_idx, k);
            check("asc_key", o_key, kv(k));
            check("asc_last", o_last, (k == 32));
            if (k == stop_at && stop_at < 32) break;
            if (inject && k == 10) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 6'd11;
                i_wr_data = '1;
            end
            tick();
            if (inject && k == 10) begin
                i_wr_en = 1'b0;
                check("stream_wr_err", o_err, 1);
            end
        end
        if (stop_at == 32) begin
            check("asc_end_valid", o_key_valid, 0);
            check("asc_end_ready", o_ready, 1);
        end
    endtask

    initial begin
        int exp_idx;
        int hs_cnt;
        bit done;
        bit r;

        // Reset state
        tick();
        tick();
        check("rst_key", o_key, 0);
        check("rst_idx", o_key_idx, 0);
        check("rst_valid", o_key_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_ready", o_ready, 0);
        check("rst_err", o_err, 0);
        i_rstn = 1'b1;
        tick();

        // Full load and ascending stream
        write_range(32);
        check("loading_not_ready", o_ready, 0);
        load_done_ok();
        stream_asc(1'b0, 32);

        // Descending stream with random backpressure
        i_decrypt = 1'b1;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        exp_idx = 32;
        hs_cnt  = 0;
        done    = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            r = 1'($urandom_range(0, 1));
            i_key_ready = r;
            check("desc_valid", o_key_valid, 1);
            check("desc_idx", o_key_idx, exp_idx);
            check("desc_key", o_key, kv(exp_idx));
            check("desc_last", o_last, (exp_idx == 0));
            tick();
            if (r) begin
                hs_cnt++;
                if (exp_idx == 0) done = 1'b1;
                else exp_idx--;
            end
        end
        check("desc_done", done, 1);
        check("desc_handshakes", hs_cnt, 33);
        check("desc_end_valid", o_key_valid, 0);
        check("desc_end_ready", o_ready, 1);

        // Out-of-range write while READY
        i_wr_en   = 1'b1;
        i_wr_addr = 6'd40;
        i_wr_data = '1;
        tick();
        i_wr_en = 1'b0;
        check("badaddr_err", o_err, 1);
        check("badaddr_ready", o_ready, 1);
        tick();
        check("err_one_cycle", o_err, 0);

        // Write during stream is ignored
        stream_asc(1'b1, 32);

        // Write together with start in READY
        i_wr_en   = 1'b1;
        i_wr_addr = 6'd5;
        i_wr_data = kv(5);
        i_start   = 1'b1;
        tick();
        i_wr_en = 1'b0;
        i_start = 1'b0;
        check("wrstart_err", o_err, 1);
        check("wrstart_ready", o_ready, 0);
        check("wrstart_valid", o_key_valid, 0);

        // Incomplete load
        write_range(31);
        i_load_done = 1'b1;
        tick();
        i_load_done = 1'b0;
        check("incomplete_err", o_err, 1);
        check("incomplete_ready", o_ready, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("empty_start_err", o_err, 1);
        check("empty_start_valid", o_key_valid, 0);
        tick();
        check("empty_idle_valid", o_key_valid, 0);
        check("empty_idle_err", o_err, 0);

        // Reset mid-stream at idx 15
        write_range(32);
        load_done_ok();
        stream_asc(1'b0, 15);
        i_rstn = 1'b0;
        #1;
        check("mrst_key", o_key, 0);
        check("mrst_idx", o_key_idx, 0);
        check("mrst_valid", o_key_valid, 0);
        check("mrst_last", o_last, 0);
        check("mrst_ready", o_ready, 0);
        check("mrst_err", o_err, 0);
        tick();
        tick();
        i_rstn = 1'b1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("mrst_start_err", o_err, 1);
        check("mrst_start_valid", o_key_valid, 0);
        write_range(32);
        load_done_ok();
        stream_asc(1'b0, 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
